// File: rtl/rle_pkg.sv
// Shared run-length encoder definitions: count width defaults and the
// encoder state encoding, shared with the decode FIFO.
package rle_pkg;

  localparam int unsigned DEF_CNT_W   = 4;
  localparam int unsigned DEF_MAX_RUN = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/REG.sv
// Enable register primitive with synchronous active-high clear.
module REG #(
  parameter int unsigned W = 1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         EN,
  input  logic [W-1:0] D,
  output logic [W-1:0] Q
);

  always_ff @(posedge CLK) begin
    if (RST)     Q <= '0;
    else if (EN) Q <= D;
  end

endmodule

// File: rtl/rle_encode.sv
// Run-length encoder: collapses runs of identical bytes into (data, count)
// pairs of 1..MAX_RUN and hands them to the decode FIFOs over valid/ready.
module rle_encode
  import rle_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned MAX_RUN = DEF_MAX_RUN
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] out_cnt,
  input  logic             out_ready
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RUN);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
  localparam int unsigned      OUT_W   = 8 + CNT_W + 1;

  logic [7:0]       run_data_q, run_data_d;
  logic [CNT_W-1:0] run_cnt_q,  run_cnt_d;
  logic [1:0]       state_raw;
  state_t           state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             out_en;
  logic             slot_free, acc, load;

  assign state_q = state_t'(state_raw);
  assign {out_data, out_cnt, out_valid} = out_q;

  assign slot_free = !out_valid | out_ready;
  assign in_ready  = (state_q != FLUSH) & slot_free;
  assign acc       = in_valid & in_ready;

  always_comb begin
    run_data_d = run_data_q;
    run_cnt_d  = run_cnt_q;
    state_d    = state_q;
    load       = 1'b0;
    unique case (state_q)
      RUN: begin
        if (acc) begin
          if (in_data == run_data_q && run_cnt_q < MAX_CNT) begin
            run_cnt_d = run_cnt_q + ONE_CNT;
          end else begin
            load       = 1'b1;
            run_data_d = in_data;
            run_cnt_d  = ONE_CNT;
          end
          state_d = in_last ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        if (slot_free) begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        // The illegal encoding behaves as IDLE so an accepted byte is never lost.
        state_d = IDLE;
        if (acc) begin
          run_data_d = in_data;
          run_cnt_d  = ONE_CNT;
          state_d    = in_last ? FLUSH : RUN;
        end
      end
    endcase
  end

  // A load in the same cycle as a transfer replaces the departing pair.
  always_comb begin
    out_en = load | (out_valid & out_ready);
    out_d  = load ? {run_data_q, run_cnt_q, 1'b1} : {out_data, out_cnt, 1'b0};
  end

  REG #(.W(8)) REG_RUN_DATA (
    .CLK(CLK), .RST(RST), .EN(1'b1), .D(run_data_d), .Q(run_data_q)
  );

  REG #(.W(CNT_W)) REG_RUN_CNT (
    .CLK(CLK), .RST(RST), .EN(1'b1), .D(run_cnt_d), .Q(run_cnt_q)
  );

  REG #(.W(2)) REG_STATE (
    .CLK(CLK), .RST(RST), .EN(1'b1), .D(state_d), .Q(state_raw)
  );

  REG #(.W(OUT_W)) REG_OUT (
    .CLK(CLK), .RST(RST), .EN(out_en), .D(out_d), .Q(out_q)
  );

endmodule
